// File: rtl/ksa16_rr_scheduler_pkg.sv
// ============================================================================
// Module   : ksa16_rr_scheduler_pkg
// Brief    : Shared constants for the shared Kogge-Stone adder scheduler:
//            adder width and the scheduler state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ksa16_rr_scheduler_pkg;

   // Width of the single shared adder instance
   localparam int KSA_W = 16;

   // Scheduler state encoding
   typedef logic [1:0] ksa_state_t;

   localparam ksa_state_t KSA_S_IDLE = 2'd0;
   localparam ksa_state_t KSA_S_CALC = 2'd1;
   localparam ksa_state_t KSA_S_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter. The search starts one past
//            ptr (mod N) and picks the first asserted request. The caller
//            owns the pointer register.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic          found;
   int            cand;
   logic [IW-1:0] cand_idx;

   // Rotating priority search: the requester just after ptr has top priority
   always_comb begin
      gnt      = '0;
      idx      = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int off = 1; off <= N; off++) begin
         cand     = (int'(ptr) + off) % N;
         cand_idx = IW'(cand);
         if (en && !found && req[cand_idx]) begin
            gnt[cand_idx] = 1'b1;
            idx           = cand_idx;
            found         = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ksa16_rr_scheduler.sv
// ============================================================================
// Module   : ksa16_rr_scheduler
// Brief    : Round-robin scheduler sharing one external 16-bit Kogge-Stone
//            adder among NREQ requesters. Operands are registered onto the
//            adder inputs, the sum/carry is captured one cycle later and
//            returned with the owner id over a valid/ready result port.
//            Optional macro KSA_SCHED_CNT_EN adds a 32-bit completed-op
//            counter output (op_count).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ksa16_rr_scheduler
   import ksa16_rr_scheduler_pkg::*;
#(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = KSA_W,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [WIDTH-1:0]      add_a,
   output logic [WIDTH-1:0]      add_b,
   input  logic [WIDTH-1:0]      add_sum,
   input  logic                  add_cout,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WIDTH-1:0]      res_sum,
   output logic                  res_cout,
   output logic [IDW-1:0]        res_id,
   output logic                  busy
`ifdef KSA_SCHED_CNT_EN
   ,
   output logic [31:0]           op_count
`endif
);

   ksa_state_t       state_q,    state_d;
   logic [IDW-1:0]   rr_ptr_q,   rr_ptr_d;
   logic [WIDTH-1:0] add_a_q,    add_a_d;
   logic [WIDTH-1:0] add_b_q,    add_b_d;
   logic [IDW-1:0]   id_q,       id_d;
   logic [WIDTH-1:0] res_sum_q,  res_sum_d;
   logic             res_cout_q, res_cout_d;
   logic [IDW-1:0]   res_id_q,   res_id_d;

   logic             arb_en;
   logic [NREQ-1:0]  arb_gnt;
   logic [IDW-1:0]   arb_idx;
   logic             accept;

   logic [WIDTH-1:0] opa_arr [NREQ];
   logic [WIDTH-1:0] opb_arr [NREQ];

   // Unpack the flat operand buses so the winner can be selected by index
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign opa_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign opb_arr[gi] = req_b[gi*WIDTH +: WIDTH];
   end

   rr_arbiter #(
      .N   (NREQ)
   ) u_arb (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .en  (arb_en),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // A grant is only ever issued on a valid request, so any grant is an accept
   assign accept = |arb_gnt;

   // State register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= KSA_S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: CALC always lasts one cycle; DONE waits for res_ready
   always_comb begin
      state_d = state_q;
      case (state_q)
         KSA_S_IDLE: if (accept) state_d = KSA_S_CALC;
         KSA_S_CALC: state_d = KSA_S_DONE;
         KSA_S_DONE: if (res_ready) state_d = accept ? KSA_S_CALC : KSA_S_IDLE;
         default:    state_d = KSA_S_IDLE;
      endcase
   end

   // Output decode: grants only while idle or while the held result drains
   always_comb begin
      arb_en    = !wb_rst_i &&
                  ((state_q == KSA_S_IDLE) || ((state_q == KSA_S_DONE) && res_ready));
      busy      = (state_q != KSA_S_IDLE);
      res_valid = (state_q == KSA_S_DONE);
      req_ready = arb_gnt;
   end

   // Datapath next values: latch operands on accept, capture adder in CALC
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      add_a_d    = add_a_q;
      add_b_d    = add_b_q;
      id_d       = id_q;
      res_sum_d  = res_sum_q;
      res_cout_d = res_cout_q;
      res_id_d   = res_id_q;
      if (accept) begin
         rr_ptr_d = arb_idx;
         add_a_d  = opa_arr[arb_idx];
         add_b_d  = opb_arr[arb_idx];
         id_d     = arb_idx;
      end
      if (state_q == KSA_S_CALC) begin
         res_sum_d  = add_sum;
         res_cout_d = add_cout;
         res_id_d   = id_q;
      end
   end

   // Datapath registers
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rr_ptr_q   <= IDW'(NREQ - 1);
         add_a_q    <= '0;
         add_b_q    <= '0;
         id_q       <= '0;
         res_sum_q  <= '0;
         res_cout_q <= 1'b0;
         res_id_q   <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         add_a_q    <= add_a_d;
         add_b_q    <= add_b_d;
         id_q       <= id_d;
         res_sum_q  <= res_sum_d;
         res_cout_q <= res_cout_d;
         res_id_q   <= res_id_d;
      end
   end

   assign add_a    = add_a_q;
   assign add_b    = add_b_q;
   assign res_sum  = res_sum_q;
   assign res_cout = res_cout_q;
   assign res_id   = res_id_q;

`ifdef KSA_SCHED_CNT_EN
   logic [31:0] op_count_q, op_count_d;

   // Count every delivered result; natural 32-bit wrap
   always_comb begin
      op_count_d = op_count_q;
      if (res_valid && res_ready) op_count_d = op_count_q + 32'd1;
   end

   // Completed-op counter register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         op_count_q <= '0;
      end else begin
         op_count_q <= op_count_d;
      end
   end

   assign op_count = op_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ksa16_rr_scheduler.sv
// ============================================================================
// Module   : tb_ksa16_rr_scheduler
// Brief    : Self-checking bench for ksa16_rr_scheduler with a behavioural
//            16-bit adder standing in for the external Kogge-Stone instance.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ksa16_rr_scheduler;

   logic        clk = 1'b0;
   logic        wb_rst_i;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_a, req_b;
   logic [15:0] add_a, add_b, add_sum;
   logic        add_cout;
   logic        res_valid, res_ready;
   logic [15:0] res_sum;
   logic        res_cout;
   logic [1:0]  res_id;
   logic        busy;
`ifdef KSA_SCHED_CNT_EN
   logic [31:0] op_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] opa [4];
   logic [15:0] opb [4];

   always #5 clk = ~clk;

   // Behavioural stand-in for the external adder
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

   ksa16_rr_scheduler #(.NREQ(4)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (wb_rst_i),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_id    (res_id),
      .busy      (busy)
`ifdef KSA_SCHED_CNT_EN
      ,
      .op_count  (op_count)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      wb_rst_i  = 1'b1;
      req_valid = 4'b0000;
      tick();
      wb_rst_i  = 1'b0;
   endtask

   task automatic test_reset();
      wb_rst_i  = 1'b1;
      req_valid = 4'b1111;
      res_ready = 1'b0;
      req_a     = '0;
      req_b     = '0;
      tick();
      tick();
      n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
      n_cmp++; if (req_ready !== 4'b0) begin n_bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
      n_cmp++; if (add_a !== 16'h0 || add_b !== 16'h0) begin n_bad++; $display("FAIL reset_add got=%h/%h want=0000/0000", add_a, add_b); end
      n_cmp++; if (res_sum !== 16'h0 || res_cout !== 1'b0 || res_id !== 2'd0) begin
         n_bad++; $display("FAIL reset_res got=%h/%b/%0d want=0000/0/0", res_sum, res_cout, res_id); end
      wb_rst_i = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL reset_first_grant got=%b want=0001", req_ready); end
      req_valid = 4'b0000;
      tick();
   endtask

   task automatic test_single_op();
      apply_reset();
      req_a[15:0] = 16'hFFFF;
      req_b[15:0] = 16'h0001;
      req_valid   = 4'b0001;
      res_ready   = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_grant got=%b want=0001", req_ready); end
      tick();
      req_valid = 4'b0000;
      n_cmp++; if (busy !== 1'b1 || res_valid !== 1'b0) begin n_bad++; $display("FAIL single_calc busy/valid got=%b/%b want=1/0", busy, res_valid); end
      n_cmp++; if (add_a !== 16'hFFFF || add_b !== 16'h0001) begin n_bad++; $display("FAIL single_add got=%h/%h want=ffff/0001", add_a, add_b); end
      tick();
      n_cmp++; if (res_valid !== 1'b1 || res_sum !== 16'h0000 || res_cout !== 1'b1 || res_id !== 2'd0) begin
         n_bad++; $display("FAIL single_result got v=%b s=%h c=%b id=%0d want v=1 s=0000 c=1 id=0", res_valid, res_sum, res_cout, res_id); end
      tick();
      n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_idle got v=%b busy=%b want 0/0", res_valid, busy); end
   endtask

   task automatic test_contention();
      logic [3:0]  expg;
      logic [16:0] exps;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         opa[i] = 16'h1000 * 16'(i + 1) + 16'(i);
         opb[i] = 16'hF0F0 + 16'(i * 7);
         req_a[i*16 +: 16] = opa[i];
         req_b[i*16 +: 16] = opb[i];
      end
      res_ready = 1'b1;
      req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 5; k++) begin
         expg = 4'b0001 << (k % 4);
         n_cmp++; if (req_ready !== expg) begin n_bad++; $display("FAIL contention_grant%0d got=%b want=%b", k, req_ready, expg); end
         if (k > 0) begin
            exps = {1'b0, opa[(k-1)%4]} + {1'b0, opb[(k-1)%4]};
            n_cmp++; if (res_valid !== 1'b1 || res_id !== 2'((k-1)%4) || {res_cout, res_sum} !== exps) begin
               n_bad++; $display("FAIL contention_res%0d got v=%b id=%0d r=%h want v=1 id=%0d r=%h", k, res_valid, res_id, {res_cout, res_sum}, (k-1)%4, exps); end
         end
         tick();
         n_cmp++; if (req_ready !== 4'b0000 || res_valid !== 1'b0) begin
            n_bad++; $display("FAIL contention_calc%0d got rdy=%b v=%b want 0000/0", k, req_ready, res_valid); end
         tick();
      end
      n_cmp++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin n_bad++; $display("FAIL contention_last got v=%b id=%0d want 1/0", res_valid, res_id); end
      req_valid = 4'b0000;
      tick();
   endtask

   task automatic test_backpressure();
      apply_reset();
      req_a[31:16] = 16'h1234;
      req_b[31:16] = 16'h4321;
      req_valid    = 4'b0010;
      res_ready    = 1'b0;
      #1;
      tick();
      req_valid = 4'b0000;
      tick();
      req_a[47:32] = 16'h00FF;
      req_b[47:32] = 16'hFF01;
      req_valid    = 4'b0100;
      #1;
      for (int c = 0; c < 5; c++) begin
         n_cmp++; if (res_valid !== 1'b1 || res_sum !== 16'h5555 || res_cout !== 1'b0 || res_id !== 2'd1 || req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL backpressure_hold%0d got v=%b s=%h c=%b id=%0d rdy=%b want 1/5555/0/1/0000", c, res_valid, res_sum, res_cout, res_id, req_ready); end
         tick();
      end
      res_ready = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL backpressure_release got=%b want=0100", req_ready); end
      tick();
      req_valid = 4'b0000;
      n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b1 || add_a !== 16'h00FF) begin
         n_bad++; $display("FAIL backpressure_next got v=%b busy=%b a=%h want 0/1/00ff", res_valid, busy, add_a); end
      tick();
      n_cmp++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_sum !== 16'h0000 || res_cout !== 1'b1) begin
         n_bad++; $display("FAIL backpressure_res2 got v=%b id=%0d s=%h c=%b want 1/2/0000/1", res_valid, res_id, res_sum, res_cout); end
      tick();
   endtask

   task automatic test_reset_midop();
      apply_reset();
      req_a[31:16] = 16'hABCD;
      req_b[31:16] = 16'h1111;
      req_valid    = 4'b0010;
      res_ready    = 1'b1;
      #1;
      tick();
      req_valid = 4'b0000;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midop_calc busy got=%b want=1", busy); end
      wb_rst_i = 1'b1;
      tick();
      n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midop_reset got v=%b busy=%b want 0/0", res_valid, busy); end
      wb_rst_i  = 1'b0;
      req_valid = 4'b1111;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL midop_ptr got=%b want=0001", req_ready); end
      req_valid = 4'b0000;
      tick();
   endtask

   task automatic test_arith_sweep();
      logic [15:0] a, b;
      logic [16:0] exps;
      logic [15:0] ba [4];
      logic [15:0] bb [4];
      int          r;
      ba[0] = 16'h0000; bb[0] = 16'h0000;
      ba[1] = 16'hFFFF; bb[1] = 16'hFFFF;
      ba[2] = 16'h8000; bb[2] = 16'h8000;
      ba[3] = 16'h7FFF; bb[3] = 16'h0001;
      apply_reset();
      res_ready = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         r = n % 4;
         if (n < 4) begin
            a = ba[n];
            b = bb[n];
         end else begin
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
         end
         exps = {1'b0, a} + {1'b0, b};
         req_a[r*16 +: 16] = a;
         req_b[r*16 +: 16] = b;
         req_valid = 4'b0001 << r;
         #1;
         tick();
         req_valid = 4'b0000;
         tick();
         n_cmp++; if ({res_cout, res_sum} !== exps || res_id !== 2'(r) || res_valid !== 1'b1) begin
            n_bad++; $display("FAIL sweep%0d a=%h b=%h got v=%b r=%h id=%0d want r=%h id=%0d", n, a, b, res_valid, {res_cout, res_sum}, res_id, exps, r); end
         tick();
      end
   endtask

`ifdef KSA_SCHED_CNT_EN
   task automatic test_counter();
      apply_reset();
      n_cmp++; if (op_count !== 32'd0) begin n_bad++; $display("FAIL count_reset got=%0d want=0", op_count); end
      req_a[15:0] = 16'h0102;
      req_b[15:0] = 16'h0304;
      res_ready   = 1'b1;
      for (int n = 0; n < 7; n++) begin
         req_valid = 4'b0001;
         #1;
         tick();
         req_valid = 4'b0000;
         tick();
         if (n == 3) begin
            res_ready = 1'b0;
            tick();
            tick();
            tick();
            n_cmp++; if (op_count !== 32'd3) begin n_bad++; $display("FAIL count_hold got=%0d want=3", op_count); end
            res_ready = 1'b1;
         end
         tick();
      end
      n_cmp++; if (op_count !== 32'd7) begin n_bad++; $display("FAIL count_final got=%0d want=7", op_count); end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog expired before completion");
      $fatal(1, "watchdog");
   end

   initial begin
      wb_rst_i  = 1'b1;
      req_valid = 4'b0000;
      res_ready = 1'b0;
      req_a     = '0;
      req_b     = '0;
      test_reset();
      test_single_op();
      test_contention();
      test_backpressure();
      test_reset_midop();
      test_arith_sweep();
`ifdef KSA_SCHED_CNT_EN
      test_counter();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
